// File: rtl/qoa_pkg.sv
// qoa_pkg: shared opcodes, FSM states and sizing for the QOA command sequencer.
// No ports; imported by the sequencer top.
package qoa_pkg;

  localparam int SLICE_SAMPLES = 20;
  localparam int LMS_WORDS     = 8;

  localparam logic [2:0] LMS_LAST = 3'(LMS_WORDS - 1);
  localparam logic [4:0] SMP_INIT = 5'(SLICE_SAMPLES);

  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_LOAD_LMS = 8'h01;
  localparam logic [7:0] OP_DECODE   = 8'h02;

  // Codes appear verbatim in the status byte.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LMS    = 3'd1,
    S_SLICE  = 3'd2,
    S_ISSUE  = 3'd3,
    S_STREAM = 3'd4
  } state_t;

endpackage

// File: rtl/qoa_cmd_sequencer_if.sv
// qoa_cmd_sequencer_if: slice/sample handshakes and abort between sequencer and decoder.
// master = sequencer (slice_valid/data, sample_ready, dec_abort out); slave = decoder.
interface qoa_cmd_sequencer_if;

  logic        slice_valid;
  logic [63:0] slice_data;
  logic        slice_ready;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        sample_ready;
  logic        dec_abort;

  modport master (
    output slice_valid, slice_data,
    output sample_ready, dec_abort,
    input  slice_ready, sample_valid,
    input  sample_data
  );

  modport slave (
    input  slice_valid, slice_data,
    input  sample_ready, dec_abort,
    output slice_ready, sample_valid,
    output sample_data
  );

endinterface

// File: rtl/qoa_tx_serializer.sv
// qoa_tx_serializer: holds one decoded sample and hands it to SPI TX hi byte then lo byte.
// Ports: clk/rst, en (streaming), accept+sample_data in, tx_load in; byte_out, full, lo_done, underrun out.
module qoa_tx_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        accept,
  input  logic [15:0] sample_data,
  input  logic        tx_load,
  output logic [7:0]  byte_out,
  output logic        full,
  output logic        lo_done,
  output logic        underrun
);

  logic [7:0] lo_hold;
  logic       lo_sel;

  assign underrun = en && tx_load && !full;
  assign lo_done  = en && tx_load && full && lo_sel;

  // Hi byte goes straight to byte_out; only the lo byte needs holding.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      lo_hold  <= '0;
      lo_sel   <= 1'b0;
      full     <= 1'b0;
      byte_out <= '0;
    end else if (accept) begin
      lo_hold  <= sample_data[7:0];
      lo_sel   <= 1'b0;
      full     <= 1'b1;
      byte_out <= sample_data[15:8];
    end else if (tx_load && full) begin
      if (lo_sel) begin
        lo_sel <= 1'b0;
        full   <= 1'b0;
      end else begin
        lo_sel   <= 1'b1;
        byte_out <= lo_hold;
      end
    end
  end

endmodule

// File: rtl/qoa_cmd_sequencer.sv
// qoa_cmd_sequencer: parses SPI bytes into LMS loads and slice decodes, streams samples back.
// Ports: clk/rst, cs_active, rx_valid/rx_byte, tx_load/tx_byte, lms_wr_*, busy, err, dec (decoder if).
module qoa_cmd_sequencer
  import qoa_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_active,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        tx_load,
  output logic [7:0]  tx_byte,
  output logic        lms_wr_en,
  output logic [2:0]  lms_wr_idx,
  output logic [15:0] lms_wr_data,
  output logic        busy,
  output logic        err,
  qoa_cmd_sequencer_if.master dec
);

  state_t      state;
  logic [2:0]  byte_cnt;
  logic [2:0]  lms_idx;
  logic [7:0]  hi_byte;
  logic [63:0] slice_sr;
  logic        slice_valid;
  logic [4:0]  count;
  logic        abort_q;
  logic [7:0]  status_q;
  logic [7:0]  ser_byte;
  logic        ser_full;
  logic        lo_done;
  logic        underrun;
  logic        stream;
  logic        drop;
  logic        sample_ready;
  logic        accept;

  assign stream       = state == S_STREAM;
  assign busy         = state != S_IDLE;
  assign drop         = busy && !cs_active;
  assign sample_ready = stream && !ser_full
                     && (count != 5'd0);
  assign accept       = sample_ready && dec.sample_valid;
  assign tx_byte      = stream ? ser_byte : status_q;

  assign dec.slice_valid  = slice_valid;
  assign dec.slice_data   = slice_sr;
  assign dec.sample_ready = sample_ready;
  assign dec.dec_abort    = abort_q;

  qoa_tx_serializer u_ser (
    .clk         (clk),
    .rst         (rst),
    .en          (stream),
    .accept      (accept),
    .sample_data (dec.sample_data),
    .tx_load     (tx_load),
    .byte_out    (ser_byte),
    .full        (ser_full),
    .lo_done     (lo_done),
    .underrun    (underrun)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      err         <= 1'b0;
      byte_cnt    <= '0;
      lms_idx     <= '0;
      hi_byte     <= '0;
      slice_sr    <= '0;
      slice_valid <= 1'b0;
      count       <= '0;
      abort_q     <= 1'b0;
      status_q    <= '0;
      lms_wr_en   <= 1'b0;
      lms_wr_idx  <= '0;
      lms_wr_data <= '0;
    end else begin
      lms_wr_en <= 1'b0;
      abort_q   <= 1'b0;
      status_q  <= {busy, err, state, 3'b000};
      // Deselect beats any byte or handshake in the same cycle.
      if (drop) begin
        state       <= S_IDLE;
        slice_valid <= 1'b0;
        byte_cnt    <= '0;
        abort_q     <= (state == S_ISSUE) || stream;
      end else begin
        unique case (state)
          S_IDLE: if (rx_valid && cs_active) begin
            byte_cnt <= '0;
            lms_idx  <= '0;
            case (rx_byte)
              OP_NOP:      err   <= 1'b0;
              OP_LOAD_LMS: state <= S_LMS;
              OP_DECODE:   state <= S_SLICE;
              default:     err   <= 1'b1;
            endcase
          end
          S_LMS: if (rx_valid) begin
            byte_cnt <= byte_cnt + 3'd1;
            if (!byte_cnt[0]) begin
              hi_byte <= rx_byte;
            end else begin
              lms_wr_en   <= 1'b1;
              lms_wr_idx  <= lms_idx;
              lms_wr_data <= {hi_byte, rx_byte};
              lms_idx     <= lms_idx + 3'd1;
              if (lms_idx == LMS_LAST)
                state <= S_IDLE;
            end
          end
          S_SLICE: if (rx_valid) begin
            slice_sr <= {slice_sr[55:0], rx_byte};
            byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd7) begin
              slice_valid <= 1'b1;
              state       <= S_ISSUE;
            end
          end
          S_ISSUE: if (dec.slice_ready) begin
            slice_valid <= 1'b0;
            count       <= SMP_INIT;
            state       <= S_STREAM;
          end
          S_STREAM: begin
            if (underrun) begin
              err     <= 1'b1;
              abort_q <= 1'b1;
              state   <= S_IDLE;
            end else begin
              if (lo_done)
                count <= count - 5'd1;
              if (count == 5'd0 && !ser_full)
                state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qoa_cmd_sequencer.sv
// tb_qoa_cmd_sequencer: randomized bench for the QOA command sequencer.
// Drives SPI bytes and a decoder model; compares against expectations built from command rules.
module tb_qoa_cmd_sequencer;
  import qoa_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_active = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_load = 1'b0;
  logic [7:0]  tx_byte;
  logic        lms_wr_en;
  logic [2:0]  lms_wr_idx;
  logic [15:0] lms_wr_data;
  logic        busy;
  logic        err;

  qoa_cmd_sequencer_if dec();

  qoa_cmd_sequencer u_dut (
    .clk         (clk),
    .rst         (rst),
    .cs_active   (cs_active),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .tx_load     (tx_load),
    .tx_byte     (tx_byte),
    .lms_wr_en   (lms_wr_en),
    .lms_wr_idx  (lms_wr_idx),
    .lms_wr_data (lms_wr_data),
    .busy        (busy),
    .err         (err),
    .dec         (dec)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit exp_err = 1'b0;

  logic [18:0] lms_log[$];
  int abort_cnt = 0;
  int sv_cnt = 0;

  logic [15:0] lms_fixed [8] = '{
    16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
    16'h1357, 16'h2468, 16'hACE0, 16'hBDF1
  };

  always @(negedge clk) begin
    if (lms_wr_en)
      lms_log.push_back({lms_wr_idx, lms_wr_data});
    if (dec.dec_abort) abort_cnt++;
    if (dec.slice_valid) sv_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte = b;
    tick();
    rx_valid = 1'b0;
    tick();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    tests++;
    if (tx_byte !== 8'h00) begin
      fails++;
      $display("FAIL reset_tx got %h exp 00", tx_byte);
    end
    tests++;
    if ({busy, err, lms_wr_en} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags got %b exp 000",
               {busy, err, lms_wr_en});
    end
    tests++;
    if ({dec.slice_valid, dec.sample_ready, dec.dec_abort}
        !== 3'b000) begin
      fails++;
      $display("FAIL reset_dec got %b exp 000",
               {dec.slice_valid, dec.sample_ready, dec.dec_abort});
    end
    rst = 1'b0;
    cs_active = 1'b1;
    tick();
  endtask

  task automatic test_load_lms(input bit fixed);
    logic [15:0] w [8];
    int base;
    for (int i = 0; i < 8; i++)
      w[i] = fixed ? lms_fixed[i] : 16'($urandom);
    base = lms_log.size();
    send(OP_LOAD_LMS);
    for (int i = 0; i < 8; i++) begin
      send(w[i][15:8]);
      send(w[i][7:0]);
    end
    tests++;
    if (lms_log.size() - base != 8) begin
      fails++;
      $display("FAIL lms_count got %0d exp 8",
               lms_log.size() - base);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (base + i >= lms_log.size() ||
          lms_log[base + i] !== {3'(i), w[i]}) begin
        fails++;
        $display("FAIL lms_word%0d got %h exp %h", i,
                 (base + i < lms_log.size()) ?
                 lms_log[base + i] : 19'h0,
                 {3'(i), w[i]});
      end
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL lms_idle busy got %b exp 0", busy);
    end
  endtask

  task automatic run_slice(input logic [7:0] sb [8],
                           input int dly);
    logic [63:0] exp_d;
    exp_d = '0;
    send(OP_DECODE);
    for (int i = 0; i < 8; i++) begin
      send(sb[i]);
      exp_d = {exp_d[55:0], sb[i]};
    end
    for (int d = 0; d <= dly; d++) begin
      tests++;
      if (dec.slice_valid !== 1'b1 ||
          dec.slice_data !== exp_d) begin
        fails++;
        $display("FAIL slice_hold c%0d got %b/%h exp 1/%h",
                 d, dec.slice_valid, dec.slice_data, exp_d);
      end
      if (d < dly) tick();
    end
    dec.slice_ready = 1'b1;
    tick();
    dec.slice_ready = 1'b0;
    tests++;
    if (dec.slice_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL slice_accept got v%b b%b exp v0 b1",
               dec.slice_valid, busy);
    end
  endtask

  task automatic run_stream(input logic [15:0] smp [20]);
    logic [7:0] expq[$];
    logic [7:0] got[$];
    int nidx, nb, cyc, abase;
    bit acc, ld;
    nidx = 0;
    nb = 0;
    cyc = 0;
    abase = abort_cnt;
    for (int i = 0; i < 20; i++) begin
      expq.push_back(smp[i][15:8]);
      expq.push_back(smp[i][7:0]);
    end
    while (nb < 40 && cyc < 3000) begin
      dec.sample_valid = (nidx < 20) &&
                         ($urandom_range(0, 2) != 0);
      dec.sample_data = (nidx < 20) ? smp[nidx] : 16'h0;
      acc = dec.sample_valid && dec.sample_ready;
      ld = (nb < 40) && !dec.sample_ready &&
           ($urandom_range(0, 1) == 1);
      tx_load = ld;
      if (ld) got.push_back(tx_byte);
      rx_valid = 1'($urandom_range(0, 1));
      rx_byte = 8'($urandom);
      tick();
      if (acc) nidx++;
      if (ld) nb++;
      cyc++;
    end
    tx_load = 1'b0;
    rx_valid = 1'b0;
    dec.sample_valid = 1'b0;
    tests++;
    if (nb != 40) begin
      fails++;
      $display("FAIL stream_timeout got %0d bytes exp 40", nb);
    end
    for (int i = 0; i < 40; i++) begin
      tests++;
      if (i >= got.size() || got[i] !== expq[i]) begin
        fails++;
        $display("FAIL stream_byte%0d got %h exp %h", i,
                 (i < got.size()) ? got[i] : 8'hxx, expq[i]);
      end
    end
    repeat (3) tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL stream_done busy got %b exp 0", busy);
    end
    tests++;
    if (tx_byte !== {1'b0, exp_err, 6'b0}) begin
      fails++;
      $display("FAIL stream_status got %h exp %h",
               tx_byte, {1'b0, exp_err, 6'b0});
    end
    tests++;
    if (abort_cnt != abase) begin
      fails++;
      $display("FAIL stream_abort got %0d exp 0",
               abort_cnt - abase);
    end
  endtask

  task automatic rand_slice(output logic [7:0] sb [8]);
    for (int i = 0; i < 8; i++) sb[i] = 8'($urandom);
  endtask

  task automatic test_decode(input bit fixed);
    logic [7:0]  sb [8];
    logic [15:0] smp [20];
    rand_slice(sb);
    for (int i = 0; i < 8; i++)
      if (fixed) sb[i] = 8'hA1 + 8'(i);
    for (int i = 0; i < 20; i++)
      smp[i] = fixed ? 16'(i + 1) : 16'($urandom);
    run_slice(sb, fixed ? 5 : $urandom_range(0, 4));
    run_stream(smp);
  endtask

  task automatic test_bad_opcode();
    logic [7:0] op;
    send(8'h7F);
    exp_err = 1'b1;
    tests++;
    if (err !== 1'b1 || tx_byte !== 8'h40) begin
      fails++;
      $display("FAIL bad_op got e%b s%h exp e1 s40",
               err, tx_byte);
    end
    for (int k = 0; k < 3; k++) begin
      op = 8'($urandom_range(3, 255));
      send(op);
      tests++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL bad_op_rand %h got e%b b%b exp e1 b0",
                 op, err, busy);
      end
    end
    send(OP_NOP);
    exp_err = 1'b0;
    tests++;
    if (err !== 1'b0 || tx_byte !== 8'h00) begin
      fails++;
      $display("FAIL nop_clear got e%b s%h exp e0 s00",
               err, tx_byte);
    end
  endtask

  task automatic test_cs_abort_slice();
    int sbase, abase;
    sbase = sv_cnt;
    abase = abort_cnt;
    send(OP_DECODE);
    for (int i = 0; i < 4; i++) send(8'($urandom));
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL cs_slice_busy got %b exp 1", busy);
    end
    cs_active = 1'b0;
    rx_valid = 1'b1;
    rx_byte = 8'($urandom);
    tick();
    rx_valid = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || sv_cnt != sbase ||
        abort_cnt != abase) begin
      fails++;
      $display("FAIL cs_slice got b%b sv%0d ab%0d exp b0 sv0 ab0",
               busy, sv_cnt - sbase, abort_cnt - abase);
    end
    cs_active = 1'b1;
    tick();
  endtask

  task automatic test_cs_abort_stream();
    logic [7:0] sb [8];
    int abase;
    rand_slice(sb);
    run_slice(sb, 0);
    abase = abort_cnt;
    dec.sample_valid = 1'b1;
    dec.sample_data = 16'h5AC3;
    tick();
    dec.sample_valid = 1'b0;
    tests++;
    if (tx_byte !== 8'h5A) begin
      fails++;
      $display("FAIL accept_hi got %h exp 5A", tx_byte);
    end
    tick();
    cs_active = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || dec.sample_ready !== 1'b0) begin
      fails++;
      $display("FAIL cs_stream got b%b r%b exp b0 r0",
               busy, dec.sample_ready);
    end
    tick();
    tests++;
    if (abort_cnt - abase != 1 || err !== exp_err) begin
      fails++;
      $display("FAIL cs_stream_abort got %0d e%b exp 1 e%b",
               abort_cnt - abase, err, exp_err);
    end
    cs_active = 1'b1;
    tick();
  endtask

  task automatic test_underrun();
    logic [7:0] sb [8];
    int abase;
    rand_slice(sb);
    run_slice(sb, 1);
    abase = abort_cnt;
    dec.sample_valid = 1'b0;
    tx_load = 1'b1;
    tick();
    tx_load = 1'b0;
    exp_err = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0 || err !== 1'b1 ||
        abort_cnt - abase != 1 || tx_byte !== 8'h40) begin
      fails++;
      $display("FAIL underrun got b%b e%b ab%0d s%h exp b0 e1 ab1 s40",
               busy, err, abort_cnt - abase, tx_byte);
    end
    send(OP_NOP);
    exp_err = 1'b0;
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL underrun_clear got %b exp 0", err);
    end
  endtask

  task automatic test_reset_midop();
    logic [7:0] sb [8];
    int abase;
    rand_slice(sb);
    run_slice(sb, 0);
    abase = abort_cnt;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if (abort_cnt != abase || busy !== 1'b0 ||
        err !== 1'b0 || tx_byte !== 8'h00) begin
      fails++;
      $display("FAIL reset_midop got ab%0d b%b e%b s%h exp 0 0 0 00",
               abort_cnt - abase, busy, err, tx_byte);
    end
  endtask

  initial begin
    dec.slice_ready = 1'b0;
    dec.sample_valid = 1'b0;
    dec.sample_data = 16'h0;
    test_reset();
    test_load_lms(1'b1);
    test_load_lms(1'b0);
    test_decode(1'b1);
    test_decode(1'b0);
    test_bad_opcode();
    test_cs_abort_slice();
    test_cs_abort_stream();
    test_underrun();
    test_reset_midop();
    test_load_lms(1'b0);
    test_decode(1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
